// File: rtl/mdu_ctrl_pkg.sv
// Shared CPU definitions: the MDU op encoding emitted by the ID-stage decoder,
// the MDU controller state encoding, and the divide-by-zero result constant.
package CPU_Defines;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } MDUOpType;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } MDUStateType;

  // Divide by zero: LO is all ones and HI returns the dividend unchanged.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic is_mul_op(input MDUOpType op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input MDUOpType op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_radix2.sv
// Unsigned 32-bit restoring divider producing one quotient bit per step.
// Signs are handled by the caller; a 32-step count freezes the result once complete.
module div_radix2 (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [5:0]  count;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dsor;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        fits;
  logic        advance;

  assign shifted = {rem, quo[31]};
  assign fits    = shifted >= {1'b0, dsor};
  // When the trial subtraction fits, the true difference is below dsor, so 32 bits suffice.
  assign diff    = shifted[31:0] - dsor;
  assign advance = step && (count != 6'd0);

  // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (start) begin
      count <= 6'd32;
    end else if (advance) begin
      count <= count - 6'd1;
    end
  end

  // NOTE: pure datapath registers carry no reset; start always loads them before they are read.
  always_ff @(posedge clk) begin
    if (start) begin
      quo  <= dividend;
      rem  <= '0;
      dsor <= divisor;
    end else if (advance) begin
      rem <= fits ? diff : shifted[31:0];
      quo <= {quo[30:0], fits};
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/mdu_ctrl.sv
// EXE-stage multiply/divide controller: sequences MULT/MULTU/DIV/DIVU, owns HI/LO,
// services MTHI/MTLO, and holds the issuing instruction in EXE until its result commits.
module mdu_ctrl
  import CPU_Defines::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  MDUOpType    EXE_MDUOp,
  input  logic        EXE_MDUValid,
  input  logic [31:0] EXE_Src0,
  input  logic [31:0] EXE_Src1,
  input  logic        EXE_Flush,
  output logic        EXE_MDUBusy,
  output logic [31:0] EXE_HiData,
  output logic [31:0] EXE_LoData
);

  MDUStateType state;
  logic [4:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] src0_q, src1_q;
  logic        sgn_q, div_q;
  logic [63:0] prod;
  logic [63:0] mul_a, mul_b;
  logic        issue_mul, issue_div;
  logic [31:0] dividend_mag, divisor_mag;
  logic [31:0] quo, rem;
  logic        q_neg, r_neg;
  logic [31:0] res_hi, res_lo;

  assign issue_mul = (state == S_IDLE) && EXE_MDUValid && !EXE_Flush && is_mul_op(EXE_MDUOp);
  assign issue_div = (state == S_IDLE) && EXE_MDUValid && !EXE_Flush && is_div_op(EXE_MDUOp);

  assign dividend_mag = ((EXE_MDUOp == MDU_DIV) && EXE_Src0[31]) ? -EXE_Src0 : EXE_Src0;
  assign divisor_mag  = ((EXE_MDUOp == MDU_DIV) && EXE_Src1[31]) ? -EXE_Src1 : EXE_Src1;

  div_radix2 u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (issue_div),
    .step      (state == S_DIV),
    .dividend  (dividend_mag),
    .divisor   (divisor_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      src0_q <= '0;
      src1_q <= '0;
      sgn_q  <= 1'b0;
      div_q  <= 1'b0;
    end else if (EXE_Flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue_mul || issue_div) begin
            src0_q <= EXE_Src0;
            src1_q <= EXE_Src1;
            sgn_q  <= (EXE_MDUOp == MDU_MULT) || (EXE_MDUOp == MDU_DIV);
            div_q  <= issue_div;
            state  <= issue_div ? S_DIV : S_MUL;
            cnt    <= issue_div ? 5'd31 : 5'(MUL_CYCLES - 1);
          end else if (EXE_MDUValid && (EXE_MDUOp == MDU_MTHI)) begin
            hi <= EXE_Src0;
          end else if (EXE_MDUValid && (EXE_MDUOp == MDU_MTLO)) begin
            lo <= EXE_Src0;
          end
        end
        S_MUL, S_DIV: begin
          if (cnt == 5'd0) state <= S_DONE;
          else             cnt   <= cnt - 5'd1;
        end
        S_DONE: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sign- or zero-extend to 64 bits; the low 64 bits of the wrapped product are exact.
  assign mul_a = {{32{sgn_q & src0_q[31]}}, src0_q};
  assign mul_b = {{32{sgn_q & src1_q[31]}}, src1_q};

  // Multicycle path from the operand registers: rewritten on every MUL cycle.
  always_ff @(posedge clk) begin
    if (state == S_MUL) prod <= mul_a * mul_b;
  end

  assign q_neg = sgn_q & (src0_q[31] ^ src1_q[31]);
  assign r_neg = sgn_q & src0_q[31];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (div_q) begin
      if (src1_q == 32'd0) begin
        res_hi = src0_q;
        res_lo = DIV0_LO;
      end else begin
        res_hi = r_neg ? -rem : rem;
        res_lo = q_neg ? -quo : quo;
      end
    end
  end

  assign EXE_MDUBusy = resetn && (issue_mul || issue_div || (state == S_MUL) || (state == S_DIV));
  assign EXE_HiData  = hi;
  assign EXE_LoData  = lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, hand-written flush/reset
// sequences, and randomized ops checked against an arithmetic HI/LO model.
module tb_mdu_ctrl;
  import CPU_Defines::*;

  localparam int MC       = 2;
  localparam int MUL_BUSY = MC + 1;
  localparam int DIV_BUSY = 33;

  logic        clk = 1'b0;
  logic        resetn;
  MDUOpType    op;
  logic        valid, flush;
  logic [31:0] src0, src1;
  logic        busy;
  logic [31:0] hi_o, lo_o;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] hi_m, lo_m;

  typedef struct {
    MDUOpType    op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy_n;
  } vec_t;

  vec_t vecs[10];

  mdu_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .EXE_MDUOp    (op),
    .EXE_MDUValid (valid),
    .EXE_Src0     (src0),
    .EXE_Src1     (src1),
    .EXE_Flush    (flush),
    .EXE_MDUBusy  (busy),
    .EXE_HiData   (hi_o),
    .EXE_LoData   (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural result computed with wide integer arithmetic, independent of the datapath.
  function automatic logic [63:0] ref_result(input MDUOpType o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] p;
    case (o)
      MDU_MULT:  begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        p = 64'(x * y);
        return p;
      end
      MDU_MULTU: begin
        x = longint'({32'd0, a});
        y = longint'({32'd0, b});
        p = 64'(x * y);
        return p;
      end
      MDU_DIV, MDU_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        x = (o == MDU_DIV) ? longint'($signed(a)) : longint'({32'd0, a});
        y = (o == MDU_DIV) ? longint'($signed(b)) : longint'({32'd0, b});
        q = x / y;
        r = x % y;
        p = {r[31:0], q[31:0]};
        return p;
      end
      default: return {hi_m, lo_m};
    endcase
  endfunction

  // Issues a long op, counts busy cycles (bounded), holds it through DONE, then retires it.
  task automatic run_op(input MDUOpType o, input logic [31:0] a, input logic [31:0] b,
                        output int nb);
    op = o; src0 = a; src1 = b; valid = 1'b1;
    #1;
    nb = 0;
    while (busy === 1'b1 && nb < 200) begin
      nb++;
      tick();
    end
    valid = 1'b0; op = MDU_NOP;
    tick();
  endtask

  task automatic do_mt(input MDUOpType o, input logic [31:0] a);
    op = o; src0 = a; valid = 1'b1;
    #1;
    check("mt_no_stall", {31'd0, busy}, 32'd0);
    tick();
    valid = 1'b0; op = MDU_NOP;
    if (o == MDU_MTHI) hi_m = a;
    else               lo_m = a;
  endtask

  initial begin
    MDUOpType    ops[6];
    MDUOpType    ro;
    logic [31:0] ra, rb;
    logic [63:0] r;
    int          nb;

    ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};

    vecs[0] = '{MDU_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_BUSY};
    vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_BUSY};
    vecs[2] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_BUSY};
    vecs[3] = '{MDU_MULT,  32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB, MUL_BUSY};
    vecs[4] = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_BUSY};
    vecs[5] = '{MDU_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, DIV_BUSY};
    vecs[6] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_BUSY};
    vecs[7] = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_BUSY};
    vecs[8] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFF, DIV_BUSY};
    vecs[9] = '{MDU_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_BUSY};

    resetn = 1'b0; valid = 1'b0; flush = 1'b0; op = MDU_NOP; src0 = '0; src1 = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    tick();
    check("reset_hi",   hi_o, 32'd0);
    check("reset_lo",   lo_o, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, nb);
      check($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(vecs[i].busy_n));
      check($sformatf("vec%0d_hi", i), hi_o, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo_o, vecs[i].lo);
      hi_m = vecs[i].hi; lo_m = vecs[i].lo;
    end

    // Flush on the tenth cycle of a divide: nothing commits, FSM back to IDLE.
    do_mt(MDU_MTHI, 32'h0000_1234);
    #1;
    check("mthi_visible", hi_o, 32'h0000_1234);
    op = MDU_DIV; src0 = 32'd1000; src1 = 32'd7; valid = 1'b1;
    #1;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b0; op = MDU_NOP;
    #1;
    check("flush_mid_busy", {31'd0, busy}, 32'd0);
    check("flush_mid_hi",   hi_o, hi_m);
    check("flush_mid_lo",   lo_o, lo_m);
    tick();
    check("flush_mid_stays_idle", {31'd0, busy}, 32'd0);

    // Flush in the DONE cycle: the commit is suppressed.
    op = MDU_DIV; src0 = 32'd1000; src1 = 32'd7; valid = 1'b1;
    #1;
    nb = 0;
    while (busy === 1'b1 && nb < 200) begin
      nb++;
      tick();
    end
    check("flush_done_busy_cycles", 32'(nb), 32'(DIV_BUSY));
    flush = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b0; op = MDU_NOP;
    #1;
    check("flush_done_busy", {31'd0, busy}, 32'd0);
    check("flush_done_hi",   hi_o, hi_m);
    check("flush_done_lo",   lo_o, lo_m);

    // Flush and issue in the same cycle: flush wins, no start.
    op = MDU_MULT; src0 = 32'd3; src1 = 32'd5; valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_issue_busy", {31'd0, busy}, 32'd0);
    tick();
    flush = 1'b0; valid = 1'b0; op = MDU_NOP;
    #1;
    check("flush_issue_no_start", {31'd0, busy}, 32'd0);
    repeat (4) tick();
    check("flush_issue_hi", hi_o, hi_m);
    check("flush_issue_lo", lo_o, lo_m);

    // MTLO followed immediately by a dependent read.
    do_mt(MDU_MTLO, 32'hA5A5_A5A5);
    valid = 1'b1;
    #1;
    check("mflo_value",    lo_o, 32'hA5A5_A5A5);
    check("mflo_no_stall", {31'd0, busy}, 32'd0);
    valid = 1'b0;

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ro = ops[$urandom_range(0, 5)];
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 16));
        2:       rb = 32'(-int'($urandom_range(1, 16)));
        default: rb = $urandom;
      endcase
      if (ro == MDU_MTHI || ro == MDU_MTLO) begin
        do_mt(ro, ra);
      end else begin
        r = ref_result(ro, ra, rb);
        run_op(ro, ra, rb, nb);
        check($sformatf("rnd%0d_busy_cycles", i), 32'(nb),
              is_div_op(ro) ? 32'(DIV_BUSY) : 32'(MUL_BUSY));
        hi_m = r[63:32]; lo_m = r[31:0];
      end
      #1;
      check($sformatf("rnd%0d_hi", i), hi_o, hi_m);
      check($sformatf("rnd%0d_lo", i), lo_o, lo_m);
    end

    // Reset asserted mid-multiply: state, HI/LO and busy clear at once.
    do_mt(MDU_MTHI, 32'hDEAD_BEEF);
    op = MDU_MULT; src0 = 32'd9; src1 = 32'd9; valid = 1'b1;
    #1;
    tick();
    check("mul_in_flight_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    #1;
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_hi",   hi_o, 32'd0);
    check("async_reset_lo",   lo_o, 32'd0);
    valid = 1'b0; op = MDU_NOP;
    tick();
    #2 resetn = 1'b1;
    tick();
    check("post_reset_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the EXE stage. Sequences MULT/MULTU (fixed-latency multiplier) and DIV/DIVU (iterative 32-step divider), owns the architectural HI/LO registers, services MTHI/MTLO/MFHI/MFLO, and raises a stall request so the instruction stays in EXE until its result commits. Sits beside the ALU. It is driven by the MDU op field produced by the ID-stage decoder and carried to EXE in the pipeline register.

## Interface
Parameters:
- MUL_CYCLES, 2, multiplier occupancy in cycles; legal range 1..4.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- EXE_MDUOp  in  MDUOpType (3)  op: MDU_NOP, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
- EXE_MDUValid  in  1  EXE holds a live instruction carrying EXE_MDUOp.
- EXE_Src0  in  32  rs value after forwarding; dividend or multiplicand; MT source.
- EXE_Src1  in  32  rt value after forwarding; divisor or multiplier.
- EXE_Flush  in  1  kill the EXE instruction this cycle (exception or eret from an older stage).
- EXE_MDUBusy  out  1  stall request to the hazard unit.
- EXE_HiData  out  32  current HI; feeds MFHI.
- EXE_LoData  out  32  current LO; feeds MFLO.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE
  - valid && (MULT/MULTU) && !flush: latch operands and signedness; go to MUL with cnt = MUL_CYCLES-1.
  - valid && (DIV/DIVU) && !flush: latch operands; go to DIV with cnt = 31.
  - valid && MTHI/MTLO && !flush: write Src0 into HI or LO at this edge; stay in IDLE.
- MUL: compute the 33x33 signed product of the sign- or zero-extended operands. When cnt == 0, go to DONE; otherwise decrement cnt.
- DIV: restoring division on operand magnitudes, one quotient bit per cycle. When cnt == 0, go to DONE.
- DONE: commit HI/LO at the edge leaving DONE, unless EXE_Flush is high; then go to IDLE. EXE_MDUValid is ignored in DONE, so the same instruction never restarts.
- EXE_Flush in any state: next state is IDLE, nothing is committed, and any in-flight divide is discarded.
- Multiply result: HI = product[63:32], LO = product[31:0].
- Divide result: LO = quotient, HI = remainder.
  - Signed: quotient sign = sign(Src0) XOR sign(Src1); remainder sign = sign(Src0).
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO = 0x80000000, HI = 0.
  - Divide by zero gives LO = 0xFFFFFFFF, HI = Src0. This takes the normal latency and raises no exception.
- EXE_MDUBusy = (IDLE && valid && MULT/MULTU/DIV/DIVU && !flush) || MUL || DIV. It is combinational and is 0 in DONE.
- EXE_HiData and EXE_LoData are the register values; there is no internal bypass.

## Timing
- Reset (asynchronous assert, synchronous deassert externally): state = IDLE, HI = LO = 0, cnt = 0, EXE_MDUBusy = 0.
- MULT: EXE occupancy is MUL_CYCLES+2 cycles (IDLE issue cycle + MUL_CYCLES + DONE). Busy is high for MUL_CYCLES+1 cycles.
- DIV: EXE occupancy is 34 cycles. Busy is high for 33 cycles.
- HI/LO become visible on the outputs the cycle after DONE. A dependent MFHI/MFLO entering EXE on that cycle reads the new value.
- MTHI/MTLO: zero stall; the value is visible the next cycle.
- MFHI/MFLO in EXE while the FSM is in MUL or DIV cannot occur, because the issuing instruction is held in EXE.
- Flush and a new issue in the same cycle: the flush wins and no start occurs.
- resetn asserted mid-divide: FSM returns to IDLE immediately, HI/LO clear, busy drops asynchronously.

## Structure
- CPU_Defines package holds:
  - MDUOpType enum, shared with Control, which emits it at ID.
  - MDUStateType enum.
  - DIV-by-zero result constants.
- Sub-module div_radix2: unsigned 32-bit iterative divider. Ports are start, dividend, divisor, quotient, remainder and a 32-step count. mdu_ctrl applies the sign fix-up before and after it.
- The multiplier is inline. The product register is written on every MUL cycle; a MUL_CYCLES-cycle multicycle path constraint applies from the operand registers to it.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003, MUL_CYCLES = 2 -> busy for 3 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> busy for 33 cycles; then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 -> LO = 0xFFFFFFFF, HI = 100 after 34 cycles. Separately, DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- HI preset to 0x1234 by MTHI, then DIV issued with EXE_Flush on cycle 10 -> FSM in IDLE next cycle, busy = 0, HI still 0x1234. Repeating with the flush in the DONE cycle gives the same result.
- MTLO 0xA5A5A5A5, then MFLO the next cycle -> EXE_LoData = 0xA5A5A5A5 with no stall. resetn pulsed mid-MULT -> HI = LO = 0 and busy low immediately.
